// File: rtl/move_sequencer.sv
// move_sequencer: arbitrates local/remote moves, screens legality, runs the
// start/ready handshake with board_updater and commits turn/ko/tx on completion.
// Optional feature macro: GO_PASS_EN (move 8'hFF = pass, two passes end the game).
module move_sequencer #(
  parameter logic        LOCAL_COLOR = 1'b0,
  parameter int unsigned UPD_TIMEOUT = 1024
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         local_valid,
  input  logic [7:0]   local_move,
  input  logic         rx_valid,
  input  logic [7:0]   rx_move,
  input  logic [161:0] board_flat,
  input  logic         upd_ready,
  input  logic         upd_suicide,
  input  logic [6:0]   upd_cap_cnt,
  input  logic [7:0]   upd_cap_pos,
  output logic         upd_start,
  output logic [7:0]   upd_move,
  output logic         upd_turn,
  output logic         board_we,
  output logic         turn,
  output logic         ko,
  output logic [7:0]   ko_pos,
  output logic         tx_valid,
  output logic [7:0]   tx_move,
  output logic         reject,
  output logic         busy,
  output logic         game_over
);

  localparam int unsigned CW = $clog2(UPD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_START, S_WAIT_UPD, S_COMMIT, S_GAME_OVER
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     cand_q, cand_d;
  logic           turn_q, turn_d;
  logic           ko_q, ko_d;
  logic [7:0]     ko_pos_q, ko_pos_d;
  logic [7:0]     upd_move_q, upd_move_d;
  logic           upd_turn_q, upd_turn_d;
  logic [7:0]     tx_move_q, tx_move_d;
  logic           reject_q, reject_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pass_q, pass_d;
`ifdef GO_PASS_EN
  logic           last_pass_q, last_pass_d;
`endif

  logic           owner_valid, other_valid, any_strobe;
  logic [7:0]     owner_move;
  logic           in_range, cell_busy, ko_hit, is_pass;
  logic [7:0]     row8, cell_idx;

  // Candidate screening: range, occupancy and ko point
  always_comb begin
    row8      = {4'b0, cand_q[7:4]};
    in_range  = (cand_q[7:4] <= 4'd8) && (cand_q[3:0] <= 4'd8);
    cell_idx  = in_range ? (row8 * 8'd18 + {3'b0, cand_q[3:0], 1'b0}) : '0;
    cell_busy = |board_flat[cell_idx +: 2];
    ko_hit    = ko_q && (cand_q == ko_pos_q);
`ifdef GO_PASS_EN
    is_pass   = (cand_q == 8'hFF);
`else
    is_pass   = 1'b0;
`endif
  end

  // Arbitration view: the side to move owns one strobe, the other is refused
  always_comb begin
    owner_valid = (turn_q == LOCAL_COLOR) ? local_valid : rx_valid;
    owner_move  = (turn_q == LOCAL_COLOR) ? local_move  : rx_move;
    other_valid = (turn_q == LOCAL_COLOR) ? rx_valid    : local_valid;
    any_strobe  = local_valid | rx_valid;
  end

  // Next-state and pulse outputs; turn/ko update on the ready edge so they
  // are visible in the same cycle as board_we
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    turn_d     = turn_q;
    ko_d       = ko_q;
    ko_pos_d   = ko_pos_q;
    upd_move_d = upd_move_q;
    upd_turn_d = upd_turn_q;
    tx_move_d  = tx_move_q;
    reject_d   = 1'b0;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
`ifdef GO_PASS_EN
    last_pass_d = last_pass_q;
`endif
    upd_start  = 1'b0;
    board_we   = 1'b0;
    tx_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        reject_d = other_valid;
        if (owner_valid) begin
          cand_d  = owner_move;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        reject_d   = any_strobe;
        upd_move_d = cand_q;
        upd_turn_d = turn_q;
        if (is_pass) begin
          pass_d  = 1'b1;
          turn_d  = ~turn_q;
          ko_d    = 1'b0;
          if (turn_q == LOCAL_COLOR) tx_move_d = cand_q;
          state_d = S_COMMIT;
        end else if (!in_range || cell_busy || ko_hit) begin
          reject_d   = 1'b1;
          upd_move_d = upd_move_q;
          upd_turn_d = upd_turn_q;
          state_d    = S_IDLE;
        end else begin
          pass_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        reject_d  = any_strobe;
        upd_start = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT_UPD;
      end
      S_WAIT_UPD: begin
        reject_d = any_strobe;
        if (upd_ready) begin
          if (upd_suicide) begin
            reject_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            turn_d   = ~turn_q;
            ko_d     = (upd_cap_cnt == 7'd1);
            if (upd_cap_cnt == 7'd1) ko_pos_d = upd_cap_pos;
            if (upd_turn_q == LOCAL_COLOR) tx_move_d = upd_move_q;
            state_d  = S_COMMIT;
          end
        end else if (cnt_q == CW'(UPD_TIMEOUT)) begin
          reject_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_COMMIT: begin
        reject_d = any_strobe;
        board_we = ~pass_q;
        tx_valid = (upd_turn_q == LOCAL_COLOR);
        state_d  = S_IDLE;
`ifdef GO_PASS_EN
        last_pass_d = pass_q;
        if (pass_q && last_pass_q) state_d = S_GAME_OVER;
`endif
      end
      S_GAME_OVER: begin
        reject_d = any_strobe;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cand_q     <= '0;
      turn_q     <= 1'b0;
      ko_q       <= 1'b0;
      ko_pos_q   <= '0;
      upd_move_q <= '0;
      upd_turn_q <= 1'b0;
      tx_move_q  <= '0;
      reject_q   <= 1'b0;
      cnt_q      <= '0;
      pass_q     <= 1'b0;
`ifdef GO_PASS_EN
      last_pass_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      turn_q     <= turn_d;
      ko_q       <= ko_d;
      ko_pos_q   <= ko_pos_d;
      upd_move_q <= upd_move_d;
      upd_turn_q <= upd_turn_d;
      tx_move_q  <= tx_move_d;
      reject_q   <= reject_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
`ifdef GO_PASS_EN
      last_pass_q <= last_pass_d;
`endif
    end
  end

  assign upd_move  = upd_move_q;
  assign upd_turn  = upd_turn_q;
  assign turn      = turn_q;
  assign ko        = ko_q;
  assign ko_pos    = ko_pos_q;
  assign tx_move   = tx_move_q;
  assign reject    = reject_q;
  assign busy      = (state_q != S_IDLE);
`ifdef GO_PASS_EN
  assign game_over = (state_q == S_GAME_OVER);
`else
  assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_move_sequencer.sv
// Directed testbench for move_sequencer (LOCAL_COLOR=0, UPD_TIMEOUT=1024).
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_move_sequencer;

  logic         clk_in = 1'b0;
  logic         reset;
  logic         local_valid, rx_valid;
  logic [7:0]   local_move, rx_move;
  logic [161:0] board_flat;
  logic         upd_ready, upd_suicide;
  logic [6:0]   upd_cap_cnt;
  logic [7:0]   upd_cap_pos;
  logic         upd_start, upd_turn, board_we, turn, ko, tx_valid, reject, busy, game_over;
  logic [7:0]   upd_move, ko_pos, tx_move;

  int n_vec = 0;
  int n_err = 0;
  int n_starts = 0;
  int starts_snap;

  move_sequencer #(.LOCAL_COLOR(1'b0), .UPD_TIMEOUT(1024)) dut (
    .clk_in(clk_in), .reset(reset),
    .local_valid(local_valid), .local_move(local_move),
    .rx_valid(rx_valid), .rx_move(rx_move),
    .board_flat(board_flat),
    .upd_ready(upd_ready), .upd_suicide(upd_suicide),
    .upd_cap_cnt(upd_cap_cnt), .upd_cap_pos(upd_cap_pos),
    .upd_start(upd_start), .upd_move(upd_move), .upd_turn(upd_turn),
    .board_we(board_we), .turn(turn), .ko(ko), .ko_pos(ko_pos),
    .tx_valid(tx_valid), .tx_move(tx_move), .reject(reject),
    .busy(busy), .game_over(game_over)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) if (upd_start === 1'b1) n_starts <= n_starts + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  // One-cycle strobe; returns in the cycle after the strobe was sampled
  task automatic strobe(input logic lv, input logic [7:0] lm, input logic rv, input logic [7:0] rm);
    local_valid = lv; local_move = lm; rx_valid = rv; rx_move = rm;
    tick();
    local_valid = 1'b0; rx_valid = 1'b0;
  endtask

  // One-cycle updater completion; returns in the cycle after upd_ready
  task automatic ready(input logic sui, input logic [6:0] cc, input logic [7:0] cp);
    upd_ready = 1'b1; upd_suicide = sui; upd_cap_cnt = cc; upd_cap_pos = cp;
    tick();
    upd_ready = 1'b0; upd_suicide = 1'b0; upd_cap_cnt = '0; upd_cap_pos = '0;
  endtask

  initial begin
    reset = 1'b1; local_valid = 1'b0; rx_valid = 1'b0; local_move = '0; rx_move = '0;
    board_flat = '0; upd_ready = 1'b0; upd_suicide = 1'b0; upd_cap_cnt = '0; upd_cap_pos = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_turn", turn, 0);
    check("rst_ko", ko, 0);
    check("rst_ko_pos", ko_pos, 0);
    check("rst_upd_move", upd_move, 0);
    check("rst_pulses", {upd_start, board_we, tx_valid, reject, game_over}, 0);

    // Local black 8'h44: start two cycles after strobe, commit after ready
    strobe(1'b1, 8'h44, 1'b0, 8'h00);
    check("t1_check_busy", busy, 1);
    check("t1_check_nostart", upd_start, 0);
    tick();
    check("t1_start", upd_start, 1);
    check("t1_upd_move", upd_move, 8'h44);
    check("t1_upd_turn", upd_turn, 0);
    tick();
    check("t1_wait_nostart", upd_start, 0);
    ready(1'b0, 7'd0, 8'h00);
    check("t1_board_we", board_we, 1);
    check("t1_turn", turn, 1);
    check("t1_tx_valid", tx_valid, 1);
    check("t1_tx_move", tx_move, 8'h44);
    check("t1_ko", ko, 0);
    tick();
    check("t1_idle", {busy, board_we, tx_valid}, 0);

    // White (remote) to move, both strobe: rx wins, local refused
    strobe(1'b1, 8'h30, 1'b1, 8'h20);
    check("t2_reject_local", reject, 1);
    tick();
    check("t2_start", upd_start, 1);
    check("t2_upd_move", upd_move, 8'h20);
    check("t2_upd_turn", upd_turn, 1);
    tick();
    ready(1'b0, 7'd1, 8'h11);
    check("t2_board_we", board_we, 1);
    check("t2_no_tx", tx_valid, 0);
    check("t2_turn", turn, 0);
    check("t2_ko", ko, 1);
    check("t2_ko_pos", ko_pos, 8'h11);
    tick();

    // Ko point refused, neighbour accepted and ko cleared
    starts_snap = n_starts;
    strobe(1'b1, 8'h11, 1'b0, 8'h00);
    tick();
    check("t3_ko_reject", reject, 1);
    check("t3_ko_idle", busy, 0);
    check("t3_ko_nostart", n_starts, starts_snap);
    strobe(1'b1, 8'h12, 1'b0, 8'h00);
    tick();
    check("t3_start", upd_start, 1);
    tick();
    ready(1'b0, 7'd0, 8'h00);
    check("t3_ko_clear", ko, 0);
    check("t3_turn", turn, 1);
    check("t3_tx_move", tx_move, 8'h12);
    tick();

    // Occupied cell, col 9, pass code and out-of-turn strobe are refused
    board_flat[61:60] = 2'b01;
    starts_snap = n_starts;
    strobe(1'b0, 8'h00, 1'b1, 8'h33);
    tick();
    check("t4_occupied", reject, 1);
    strobe(1'b0, 8'h00, 1'b1, 8'h49);
    tick();
    check("t4_col9", reject, 1);
`ifndef GO_PASS_EN
    strobe(1'b0, 8'h00, 1'b1, 8'hFF);
    tick();
    check("t4_ff_range", reject, 1);
`endif
    strobe(1'b1, 8'h22, 1'b0, 8'h00);
    check("t4_out_of_turn", reject, 1);
    check("t4_oot_idle", busy, 0);
    check("t4_no_start", n_starts, starts_snap);
    check("t4_turn", turn, 1);
    tick();
    check("t4_reject_one_cycle", reject, 0);

    // Updater never answers: abort after the timeout, strobe while busy dropped
    strobe(1'b0, 8'h00, 1'b1, 8'h55);
    tick();
    check("t5_start", upd_start, 1);
    tick();
    strobe(1'b1, 8'h66, 1'b0, 8'h00);
    check("t5_busy_reject", reject, 1);
    check("t5_busy_still", busy, 1);
    for (int unsigned k = 2; k < 1025; k++) tick();
    check("t5_before_timeout", busy, 1);
    tick();
    check("t5_timeout_reject", reject, 1);
    check("t5_timeout_idle", busy, 0);
    check("t5_turn_kept", turn, 1);

    // Self-capture: refused without commit
    strobe(1'b0, 8'h00, 1'b1, 8'h56);
    tick();
    tick();
    ready(1'b1, 7'd0, 8'h00);
    check("t6_suicide_reject", reject, 1);
    check("t6_no_we", board_we, 0);
    check("t6_turn", turn, 1);
    check("t6_idle", busy, 0);

    // Reset while waiting: back to reset values, a late ready is ignored
    strobe(1'b0, 8'h00, 1'b1, 8'h57);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ready(1'b0, 7'd1, 8'h07);
    check("t7_rst_idle", busy, 0);
    check("t7_rst_turn", turn, 0);
    check("t7_rst_no_we", board_we, 0);
    check("t7_rst_ko", ko, 0);
    check("t7_rst_upd_move", upd_move, 0);

`ifdef GO_PASS_EN
    // Two passes end the game; later strobes refused; reset recovers
    strobe(1'b1, 8'hFF, 1'b0, 8'h00);
    tick();
    check("t8_pass_no_we", board_we, 0);
    check("t8_pass_tx", {tx_valid, tx_move}, 9'h1FF);
    check("t8_pass_turn", turn, 1);
    tick();
    strobe(1'b0, 8'h00, 1'b1, 8'hFF);
    tick();
    check("t8_pass2_no_tx", tx_valid, 0);
    tick();
    check("t8_game_over", game_over, 1);
    strobe(1'b0, 8'h00, 1'b1, 8'h01);
    check("t8_go_reject", reject, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("t8_go_cleared", game_over, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
